memory_stage: RTL and testbench

//  Pipeline MEM stage, directly downstream of execute. Registers one excute_data_t per cycle,

---
 rtl/memory_stage_pkg.sv | 64 ++++++
 rtl/memory_stage_mem_align.sv | 45 ++++
 rtl/memory_stage.sv | 106 ++++++++++
 tb/tb_memory_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared types for the MEM stage: op encoding, access sizes, stage payloads and op classifiers.
package memory_stage_pkg;

    typedef enum logic [4:0] {
        OP_NOP, OP_ADD, OP_SUB,
        OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
        OP_SB, OP_SH, OP_SW, OP_SD
    } op_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_ADDR,
        S_WAIT_DATA
    } mem_state_t;

    typedef struct packed {
        op_t  op;
        logic reg_write;
    } ctl_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [63:0] rd2;
        logic [63:0] result;
    } excute_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [63:0] result;
    } memory_data_t;

    function automatic logic is_load(input op_t op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
    endfunction

    function automatic logic is_store(input op_t op);
        return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
    endfunction

    function automatic msize_t op_size(input op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return MSIZE1;
            OP_LH, OP_LHU, OP_SH: return MSIZE2;
            OP_LW, OP_LWU, OP_SW: return MSIZE4;
            default:              return MSIZE8;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_mem_align.sv
// Combinational byte-lane logic: store data/strobe packing and load shift/extend.
module mem_align
    import memory_stage_pkg::*;
(
    input  op_t         op,
    input  logic [2:0]  addr_lo,
    input  logic [63:0] store_data,
    input  logic [63:0] load_raw,
    output msize_t      size,
    output logic [7:0]  strobe,
    output logic [63:0] wdata,
    output logic [63:0] load_result
);

    logic [5:0]  shamt;
    logic [7:0]  base_mask;
    logic [63:0] lane;

    always_comb begin
        shamt = {addr_lo, 3'b000};
        size  = op_size(op);
        wdata = store_data << shamt;

        case (size)
            MSIZE1:  base_mask = 8'h01;
            MSIZE2:  base_mask = 8'h03;
            MSIZE4:  base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
        strobe = is_store(op) ? (base_mask << addr_lo) : 8'h00;

        // Misaligned addresses simply shift further; bytes pushed past lane 7 are dropped.
        lane = load_raw >> shamt;
        case (op)
            OP_LB:   load_result = {{56{lane[7]}},  lane[7:0]};
            OP_LH:   load_result = {{48{lane[15]}}, lane[15:0]};
            OP_LW:   load_result = {{32{lane[31]}}, lane[31:0]};
            OP_LBU:  load_result = {56'd0, lane[7:0]};
            OP_LHU:  load_result = {48'd0, lane[15:0]};
            OP_LWU:  load_result = {32'd0, lane[31:0]};
            default: load_result = lane;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: data-bus handshake FSM, upstream stall, and the MEM/WB register.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int AXLEN = 64,
    parameter int DXLEN = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  excute_data_t       dataE,
    output memory_data_t       dataM,
    output logic               stall_m,
    output logic               dreq_valid,
    output logic [AXLEN-1:0]   dreq_addr,
    output logic [2:0]         dreq_size,
    output logic [DXLEN/8-1:0] dreq_strobe,
    output logic [DXLEN-1:0]   dreq_data,
    input  logic               dresp_addr_ok,
    input  logic               dresp_data_ok,
    input  logic [DXLEN-1:0]   dresp_data
);

    mem_state_t   state_q, state_d;
    memory_data_t data_m_q, data_m_d;
    logic         is_mem;
    logic         done;
    msize_t       size;
    logic [63:0]  load_result;

    mem_align u_align (
        .op          (dataE.ctl.op),
        .addr_lo     (dataE.result[2:0]),
        .store_data  (dataE.rd2),
        .load_raw    (dresp_data),
        .size        (size),
        .strobe      (dreq_strobe),
        .wdata       (dreq_data),
        .load_result (load_result)
    );

    assign dreq_addr = dataE.result[AXLEN-1:0];
    assign dreq_size = size;
    assign dataM     = data_m_q;

    always_comb begin
        is_mem     = dataE.valid && (is_load(dataE.ctl.op) || is_store(dataE.ctl.op));
        state_d    = state_q;
        dreq_valid = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // data_ok without a request in flight is a stale response and is dropped.
                if (is_mem) begin
                    dreq_valid = 1'b1;
                    if (dresp_addr_ok) begin
                        done    = dresp_data_ok;
                        state_d = dresp_data_ok ? S_IDLE : S_WAIT_DATA;
                    end else begin
                        state_d = S_WAIT_ADDR;
                    end
                end
            end
            S_WAIT_ADDR: begin
                dreq_valid = 1'b1;
                if (dresp_addr_ok) begin
                    done    = dresp_data_ok;
                    state_d = dresp_data_ok ? S_IDLE : S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (dresp_data_ok) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        stall_m = is_mem && !done;
    end

    always_comb begin
        data_m_d       = data_m_q;
        data_m_d.valid = 1'b0;
        if (!stall_m && dataE.valid) begin
            data_m_d.valid     = 1'b1;
            data_m_d.pc        = dataE.pc;
            data_m_d.raw_instr = dataE.raw_instr;
            data_m_d.ctl       = dataE.ctl;
            data_m_d.dst       = dataE.dst;
            data_m_d.result    = is_load(dataE.ctl.op) ? load_result : dataE.result;
        end
    end

    always_ff @(posedge clk) begin
        data_m_q <= data_m_d;
        if (reset) begin
            state_q        <= S_IDLE;
            data_m_q.valid <= 1'b0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Scenario bench for memory_stage with a retirement scoreboard.
`timescale 1ns/1ps
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    excute_data_t dataE;
    memory_data_t dataM;
    logic         stall_m, dreq_valid;
    logic [63:0]  dreq_addr, dreq_data, dresp_data;
    logic [2:0]   dreq_size;
    logic [7:0]   dreq_strobe;
    logic         dresp_addr_ok, dresp_data_ok;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] result;
    } ret_t;

    typedef struct packed {
        op_t         op;
        logic [63:0] addr;
        logic [63:0] word;
        logic [63:0] exp_val;
        logic [7:0]  exp_strobe;
        logic [2:0]  exp_size;
    } vec_t;

    ret_t sb[$];
    ret_t got[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    memory_stage #(.AXLEN(64), .DXLEN(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .dataE         (dataE),
        .dataM         (dataM),
        .stall_m       (stall_m),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data)
    );

    task automatic drive_point();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        ret_t r;
        @(negedge clk);
        if (!reset && dataM.valid === 1'b1) begin
            r.pc     = dataM.pc;
            r.result = dataM.result;
            got.push_back(r);
        end
    endtask

    task automatic issue(input op_t op, input logic [63:0] pc, input logic [63:0] res, input logic [63:0] rd2);
        dataE.valid         = 1'b1;
        dataE.pc            = pc;
        dataE.raw_instr     = pc[31:0] ^ 32'h0000_0013;
        dataE.ctl.op        = op;
        dataE.ctl.reg_write = 1'b1;
        dataE.dst           = 5'd7;
        dataE.rd2           = rd2;
        dataE.result        = res;
    endtask

    task automatic bus(input logic a_ok, input logic d_ok, input logic [63:0] d);
        dresp_addr_ok = a_ok;
        dresp_data_ok = d_ok;
        dresp_data    = d;
    endtask

    task automatic push_exp(input logic [63:0] pc, input logic [63:0] res);
        ret_t e;
        e.pc     = pc;
        e.result = res;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        repeat (3) drive_point();
        sample();
        n_tests++;
        if (dataM.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", dataM.valid); end
        n_tests++;
        if (stall_m !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, required 0", stall_m); end
        n_tests++;
        if (dreq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dreq_valid: got %b, required 0", dreq_valid); end
        drive_point();
        reset = 1'b0;
        sample();
    endtask

    task automatic test_alu();
        ret_t g, e;
        drive_point();
        issue(OP_ADD, 64'h100, 64'h1234, 64'h0);
        bus(1'b0, 1'b0, 64'h0);
        push_exp(64'h100, 64'h1234);
        sample();
        n_tests++;
        if ({stall_m, dreq_valid, dataM.valid} !== 3'b000) begin
            n_fail++; $display("FAIL alu_issue: stall/dreq_valid/dataM.valid got %b, required 000", {stall_m, dreq_valid, dataM.valid});
        end
        drive_point();
        dataE.valid = 1'b0;
        sample();
        n_tests++;
        if (dataM.valid !== 1'b1) begin n_fail++; $display("FAIL alu_latency: dataM.valid got %b, required 1", dataM.valid); end
        repeat (2) begin drive_point(); sample(); end
        n_tests++;
        if (got.size() != sb.size()) begin n_fail++; $display("FAIL alu_retire_count: got %0d, required %0d", got.size(), sb.size()); end
        while (got.size() > 0 && sb.size() > 0) begin
            g = got.pop_front(); e = sb.pop_front(); n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL alu_retire: got pc=%h res=%h, required pc=%h res=%h", g.pc, g.result, e.pc, e.result); end
        end
        got.delete(); sb.delete();
    endtask

    task automatic test_loads();
        ret_t g, e;
        vec_t v[7];
        v[0] = '{OP_LB,  64'h1003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 3'd0};
        v[1] = '{OP_LWU, 64'h0004, 64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF, 8'h00, 3'd2};
        v[2] = '{OP_LH,  64'h0012, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001, 8'h00, 3'd1};
        v[3] = '{OP_LHU, 64'h0016, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001, 8'h00, 3'd1};
        v[4] = '{OP_LW,  64'h0020, 64'h1234_5678_8765_4321, 64'hFFFF_FFFF_8765_4321, 8'h00, 3'd2};
        v[5] = '{OP_LD,  64'h0028, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'h00, 3'd3};
        v[6] = '{OP_LBU, 64'h0037, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB, 8'h00, 3'd0};
        for (int i = 0; i < 7; i++) begin
            drive_point();
            issue(v[i].op, 64'h200 + 64'(4 * i), v[i].addr, 64'h0);
            bus(1'b1, 1'b1, v[i].word);
            push_exp(64'h200 + 64'(4 * i), v[i].exp_val);
            sample();
            n_tests++;
            if ({stall_m, dreq_valid, dreq_strobe, dreq_size, dreq_addr} !== {1'b0, 1'b1, 8'h00, v[i].exp_size, v[i].addr}) begin
                n_fail++;
                $display("FAIL load_req[%0d]: stall=%b dreq_valid=%b strobe=%h size=%0d addr=%h, required 0 1 00 %0d %h",
                         i, stall_m, dreq_valid, dreq_strobe, dreq_size, dreq_addr, v[i].exp_size, v[i].addr);
            end
        end
        drive_point();
        dataE.valid = 1'b0;
        bus(1'b0, 1'b0, 64'h0);
        sample();
        repeat (2) begin drive_point(); sample(); end
        n_tests++;
        if (got.size() != sb.size()) begin n_fail++; $display("FAIL load_retire_count: got %0d, required %0d", got.size(), sb.size()); end
        while (got.size() > 0 && sb.size() > 0) begin
            g = got.pop_front(); e = sb.pop_front(); n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL load_retire: got pc=%h res=%h, required pc=%h res=%h", g.pc, g.result, e.pc, e.result); end
        end
        got.delete(); sb.delete();
    endtask

    task automatic test_store_wait();
        ret_t g, e;
        int   stall_cnt = 0;
        drive_point();
        issue(OP_SH, 64'h500, 64'h2006, 64'h0000_0000_0000_BEEF);
        push_exp(64'h500, 64'h2006);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) drive_point();
            bus(c == 2, c == 5, 64'h0);
            sample();
            if (stall_m === 1'b1) stall_cnt++;
            n_tests++;
            if ({dreq_valid, dreq_strobe, dreq_data, dataM.valid} !== {(c <= 2), 8'hC0, 64'hBEEF_0000_0000_0000, 1'b0}) begin
                n_fail++;
                $display("FAIL store_wait_c%0d: dreq_valid=%b strobe=%h data=%h dataM.valid=%b, required %b c0 beef000000000000 0",
                         c, dreq_valid, dreq_strobe, dreq_data, dataM.valid, (c <= 2));
            end
        end
        n_tests++;
        if (stall_cnt != 5) begin n_fail++; $display("FAIL store_stall_cycles: got %0d, required 5", stall_cnt); end
        drive_point();
        dataE.valid = 1'b0;
        bus(1'b0, 1'b0, 64'h0);
        sample();
        n_tests++;
        if (dataM.valid !== 1'b1) begin n_fail++; $display("FAIL store_retire_valid: got %b, required 1", dataM.valid); end
        drive_point();
        sample();
        n_tests++;
        if (dataM.valid !== 1'b0) begin n_fail++; $display("FAIL store_single_valid: got %b, required 0", dataM.valid); end
        n_tests++;
        if (got.size() != sb.size()) begin n_fail++; $display("FAIL store_retire_count: got %0d, required %0d", got.size(), sb.size()); end
        while (got.size() > 0 && sb.size() > 0) begin
            g = got.pop_front(); e = sb.pop_front(); n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL store_retire: got pc=%h res=%h, required pc=%h res=%h", g.pc, g.result, e.pc, e.result); end
        end
        got.delete(); sb.delete();
    endtask

    task automatic test_store_pack();
        vec_t v[3];
        logic [63:0] rd2s[3];
        logic [63:0] exp_data[3];
        v[0] = '{OP_SB, 64'h0005, 64'h0, 64'h0, 8'h20, 3'd0};
        v[1] = '{OP_SW, 64'h0004, 64'h0, 64'h0, 8'hF0, 3'd2};
        v[2] = '{OP_SH, 64'h0002, 64'h0, 64'h0, 8'h0C, 3'd1};
        rd2s[0] = 64'h0000_0000_0000_00AA; exp_data[0] = 64'h0000_AA00_0000_0000;
        rd2s[1] = 64'h0000_0000_1122_3344; exp_data[1] = 64'h1122_3344_0000_0000;
        rd2s[2] = 64'h0000_0000_0000_BEEF; exp_data[2] = 64'h0000_0000_BEEF_0000;
        for (int i = 0; i < 3; i++) begin
            drive_point();
            issue(v[i].op, 64'h600 + 64'(4 * i), v[i].addr, rd2s[i]);
            bus(1'b1, 1'b1, 64'h0);
            sample();
            n_tests++;
            if ({stall_m, dreq_strobe, dreq_size, dreq_data} !== {1'b0, v[i].exp_strobe, v[i].exp_size, exp_data[i]}) begin
                n_fail++;
                $display("FAIL store_pack[%0d]: stall=%b strobe=%h size=%0d data=%h, required 0 %h %0d %h",
                         i, stall_m, dreq_strobe, dreq_size, dreq_data, v[i].exp_strobe, v[i].exp_size, exp_data[i]);
            end
        end
        drive_point();
        dataE.valid = 1'b0;
        bus(1'b0, 1'b0, 64'h0);
        sample();
        drive_point();
        sample();
        n_tests++;
        if (got.size() != 3) begin n_fail++; $display("FAIL store_pack_retire_count: got %0d, required 3", got.size()); end
        got.delete(); sb.delete();
    endtask

    task automatic test_reset_mid_access();
        ret_t g, e;
        drive_point();
        issue(OP_LD, 64'h400, 64'h40, 64'h0);
        bus(1'b1, 1'b0, 64'h0);
        sample();
        drive_point();
        reset = 1'b1;
        dataE.valid = 1'b0;
        bus(1'b0, 1'b0, 64'h0);
        sample();
        drive_point();
        reset = 1'b0;
        sample();
        n_tests++;
        if ({stall_m, dreq_valid, dataM.valid} !== 3'b000) begin
            n_fail++; $display("FAIL rst_mid_state: stall/dreq_valid/dataM.valid got %b, required 000", {stall_m, dreq_valid, dataM.valid});
        end
        // Late response lands while a fresh load is waiting for addr_ok.
        drive_point();
        issue(OP_LD, 64'h408, 64'h48, 64'h0);
        bus(1'b0, 1'b1, 64'hDEAD_DEAD_DEAD_DEAD);
        push_exp(64'h408, 64'h0000_0000_0000_0077);
        sample();
        n_tests++;
        if ({stall_m, dreq_valid, dataM.valid} !== 3'b110) begin
            n_fail++; $display("FAIL rst_late_ignored: stall/dreq_valid/dataM.valid got %b, required 110", {stall_m, dreq_valid, dataM.valid});
        end
        drive_point();
        bus(1'b1, 1'b1, 64'h0000_0000_0000_0077);
        sample();
        n_tests++;
        if ({stall_m, dreq_valid} !== 2'b01) begin n_fail++; $display("FAIL rst_reissue: stall/dreq_valid got %b, required 01", {stall_m, dreq_valid}); end
        drive_point();
        dataE.valid = 1'b0;
        bus(1'b0, 1'b0, 64'h0);
        sample();
        drive_point();
        sample();
        n_tests++;
        if (got.size() != sb.size()) begin n_fail++; $display("FAIL rst_retire_count: got %0d, required %0d", got.size(), sb.size()); end
        while (got.size() > 0 && sb.size() > 0) begin
            g = got.pop_front(); e = sb.pop_front(); n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL rst_retire: got pc=%h res=%h, required pc=%h res=%h", g.pc, g.result, e.pc, e.result); end
        end
        got.delete(); sb.delete();
    endtask

    task automatic test_back_to_back();
        ret_t g, e;
        int   req_cnt = 0;
        drive_point();
        issue(OP_LD, 64'h300, 64'h100, 64'h0);
        bus(1'b1, 1'b1, 64'h1111_2222_3333_4444);
        push_exp(64'h300, 64'h1111_2222_3333_4444);
        sample();
        if (dreq_valid === 1'b1) req_cnt++;
        n_tests++;
        if ({stall_m, dreq_addr} !== {1'b0, 64'h100}) begin n_fail++; $display("FAIL b2b_ld_req: stall=%b addr=%h, required 0 100", stall_m, dreq_addr); end
        drive_point();
        issue(OP_SD, 64'h304, 64'h108, 64'hCAFE_F00D_DEAD_BEEF);
        bus(1'b1, 1'b1, 64'h0);
        push_exp(64'h304, 64'h108);
        sample();
        if (dreq_valid === 1'b1) req_cnt++;
        n_tests++;
        if ({stall_m, dreq_addr, dreq_strobe, dreq_data} !== {1'b0, 64'h108, 8'hFF, 64'hCAFE_F00D_DEAD_BEEF}) begin
            n_fail++; $display("FAIL b2b_sd_req: stall=%b addr=%h strobe=%h data=%h, required 0 108 ff cafef00ddeadbeef",
                               stall_m, dreq_addr, dreq_strobe, dreq_data);
        end
        drive_point();
        dataE.valid = 1'b0;
        bus(1'b0, 1'b0, 64'h0);
        sample();
        if (dreq_valid === 1'b1) req_cnt++;
        drive_point();
        sample();
        if (dreq_valid === 1'b1) req_cnt++;
        n_tests++;
        if (req_cnt != 2) begin n_fail++; $display("FAIL b2b_req_count: got %0d, required 2", req_cnt); end
        n_tests++;
        if (got.size() != sb.size()) begin n_fail++; $display("FAIL b2b_retire_count: got %0d, required %0d", got.size(), sb.size()); end
        while (got.size() > 0 && sb.size() > 0) begin
            g = got.pop_front(); e = sb.pop_front(); n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL b2b_retire: got pc=%h res=%h, required pc=%h res=%h", g.pc, g.result, e.pc, e.result); end
        end
        got.delete(); sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        dataE = '0;
        bus(1'b0, 1'b0, 64'h0);
        test_reset();
        test_alu();
        test_loads();
        test_store_wait();
        test_store_pack();
        test_reset_mid_access();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
